// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared opcodes, NOP encoding and fetch FSM state type
package pc_fetch_unit_pkg;

  // RV32I major opcodes seen by the fetch/commit path
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_ECALL  = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // A fetch target is usable only on a 4-byte boundary
  function automatic logic pc_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// rtl/pc_fetch_unit_next_pc_calc.sv - combinational next-PC mux and adders
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic        branch_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        bcond_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] seq_pc_o
);

  logic [31:0] pc_rel;
  logic [31:0] reg_rel;

  assign seq_pc_o = pc_i + 32'd4;
  assign pc_rel   = pc_i + imm_i;
  assign reg_rel  = rs1_data_i + imm_i;

  // jalr beats jal beats a taken branch; everything else falls through
  always_comb begin
    next_pc_o = seq_pc_o;
    if (is_jalr_i) begin
      next_pc_o = reg_rel & ~32'h1;
    end else if (is_jal_i) begin
      next_pc_o = pc_rel;
    end else if (branch_i && bcond_i) begin
      next_pc_o = pc_rel;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch/execute sequencer with PC, held instruction and retire counter; optional ECALL_HALT_EN
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] ECALL_EXIT_CODE = 32'd10
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        bcond,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] x17_data,
  output logic [31:0] pc,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  retired_q, retired_d;
  logic         misaligned_q, misaligned_d;

  logic [31:0]  next_pc;
  logic [31:0]  seq_pc;
  logic         ecall_halt;

  next_pc_calc u_next_pc_calc (
    .pc_i       (pc_q),
    .imm_i      (imm),
    .rs1_data_i (rs1_data),
    .branch_i   (branch),
    .is_jal_i   (is_jal),
    .is_jalr_i  (is_jalr),
    .bcond_i    (bcond),
    .next_pc_o  (next_pc),
    .seq_pc_o   (seq_pc)
  );

`ifdef ECALL_HALT_EN
  assign ecall_halt = (inst_q[6:0] == OPCODE_ECALL) && (x17_data == ECALL_EXIT_CODE);
`else
  // ECALL is an ordinary sequential instruction in this build
  logic unused_ecall;
  assign unused_ecall = ^(x17_data ^ ECALL_EXIT_CODE);
  assign ecall_halt   = 1'b0;
`endif

  // Sequencing, commit and halt decisions; registers hold unless a state updates them
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    retired_d    = retired_q;
    misaligned_d = misaligned_q;
    imem_req     = 1'b0;
    inst_valid   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        inst_valid = 1'b1;
        retired_d  = retired_q + 32'd1;
        if (ecall_halt) begin
          pc_d    = seq_pc;
          state_d = HALT;
        end else begin
          pc_d = next_pc;
          if (pc_misaligned(next_pc)) begin
            misaligned_d = 1'b1;
            state_d      = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and architectural registers; reset aborts any in-flight fetch or commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      retired_q    <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      retired_q    <= retired_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign retired    = retired_q;
  assign misaligned = misaligned_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized bench with behavioural model for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] RP   = 32'h0000_0000;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0, bcond = 1'b0;
  logic [31:0] imm = 32'h0, rs1_data = 32'h0, x17_data = 32'h0;
  logic [31:0] pc;
  logic        halted;
  logic        misaligned;
  logic [31:0] retired;

  int total = 0;
  int bad = 0;

  // model: architectural view only -- a PC, a held word, whether that word still awaits execution
  logic [31:0] m_pc, m_inst, m_ret;
  bit          m_halt, m_mis, m_pending;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .branch     (branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .bcond      (bcond),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .x17_data   (x17_data),
    .pc         (pc),
    .halted     (halted),
    .misaligned (misaligned),
    .retired    (retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("imem_req",   {31'b0, imem_req},   {31'b0, !m_halt && !m_pending});
    chk("imem_addr",  imem_addr,           m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_pending});
    chk("pc",         pc,                  m_pc);
    chk("inst",       inst,                m_inst);
    chk("retired",    retired,             m_ret);
    chk("halted",     {31'b0, halted},     {31'b0, m_halt});
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          ecall;
    if (reset) begin
      m_pc = RP; m_inst = NOPW; m_ret = 0; m_halt = 0; m_mis = 0; m_pending = 0;
    end else if (m_halt) begin
      // frozen
    end else if (m_pending) begin
      if (is_jalr)              tgt = (rs1_data + imm) & 32'hFFFF_FFFE;
      else if (is_jal)          tgt = m_pc + imm;
      else if (branch && bcond) tgt = m_pc + imm;
      else                      tgt = m_pc + 4;
`ifdef ECALL_HALT_EN
      ecall = (m_inst[6:0] == 7'h73) && (x17_data == 32'd10);
`else
      ecall = 0;
`endif
      m_ret = m_ret + 1;
      m_pending = 0;
      if (ecall) begin
        m_pc = m_pc + 4;
        m_halt = 1;
      end else begin
        m_pc = tgt;
        if (tgt % 4 != 0) begin
          m_halt = 1;
          m_mis = 1;
        end
      end
    end else if (imem_ready) begin
      m_inst = imem_rdata;
      m_pending = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_ctrl();
    branch = 0; is_jal = 0; is_jalr = 0; bcond = 0; imm = 0; rs1_data = 0;
  endtask

  task automatic do_reset();
    reset = 1; imem_ready = 0; clear_ctrl();
    tick();
    reset = 0;
  endtask

  // one instruction: fetched immediately, then executed with the given control outcomes
  task automatic exec_one(input logic [31:0] word, input bit jr, input bit j, input bit br,
                          input bit bc, input logic [31:0] im, input logic [31:0] r1);
    imem_rdata = word; imem_ready = 1;
    tick();
    imem_ready = 0;
    is_jalr = jr; is_jal = j; branch = br; bcond = bc; imm = im; rs1_data = r1;
    tick();
    clear_ctrl();
  endtask

  int vcnt;
  int halt_cnt;
  logic [31:0] r;

  initial begin
    // reset state
    reset = 1;
    @(negedge clk);
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_retired", retired, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    reset = 0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    @(negedge clk);

    // back-to-back sequential instructions
    imem_ready = 1; imem_rdata = NOPW; vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inst_valid) vcnt++;
    end
    chk("seq_pc", pc, 32'd12);
    chk("seq_retired", retired, 32'd3);
    chk("seq_valid_pulses", vcnt, 32'd3);

    // memory stall
    imem_ready = 0; vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (inst_valid) vcnt++;
    end
    chk("stall_pc", pc, 32'd12);
    chk("stall_valid", vcnt, 32'd0);
    chk("stall_req", {31'b0, imem_req}, 32'h1);
    imem_ready = 1; imem_rdata = NOPW;
    tick();
    chk("commit_after_ready", {31'b0, inst_valid}, 32'h1);
    imem_ready = 0;
    tick();
    chk("stall_pc_after", pc, 32'd16);

    // branches around 0x100
    exec_one(32'h0000_006F, 0, 1, 0, 0, 32'h0000_00F0, 0);
    chk("jal_pc", pc, 32'h100);
    exec_one(32'h0000_0063, 0, 0, 1, 1, 32'hFFFF_FFF0, 0);
    chk("br_taken_pc", pc, 32'hF0);
    exec_one(32'h0000_006F, 0, 1, 0, 0, 32'h0000_0010, 0);
    exec_one(32'h0000_0063, 0, 0, 1, 0, 32'hFFFF_FFF0, 0);
    chk("br_not_taken_pc", pc, 32'h104);
    chk("br_retired", retired, 32'd8);

    // ECALL
`ifdef ECALL_HALT_EN
    x17_data = 32'd9;
    exec_one(32'h0000_0073, 0, 0, 0, 0, 0, 0);
    chk("ecall9_pc", pc, 32'h108);
    chk("ecall9_halted", {31'b0, halted}, 32'h0);
    x17_data = 32'd10;
    exec_one(32'h0000_0073, 0, 0, 0, 0, 0, 0);
    chk("ecall10_pc", pc, 32'h10C);
    chk("ecall10_halted", {31'b0, halted}, 32'h1);
    chk("ecall10_retired", retired, 32'd10);
    imem_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("ecall_frozen_pc", pc, 32'h10C);
    chk("ecall_frozen_ret", retired, 32'd10);
    chk("ecall_frozen_mis", {31'b0, misaligned}, 32'h0);
`else
    x17_data = 32'd10;
    exec_one(32'h0000_0073, 0, 0, 0, 0, 0, 0);
    chk("ecall_seq_pc", pc, 32'h108);
    chk("ecall_seq_halted", {31'b0, halted}, 32'h0);
    chk("ecall_seq_retired", retired, 32'd9);
`endif

    // misaligned jalr (jalr wins over jal)
    do_reset();
    exec_one(32'h0000_0067, 1, 1, 0, 0, 32'h0, 32'h203);
    chk("mis_pc", pc, 32'h202);
    chk("mis_flag", {31'b0, misaligned}, 32'h1);
    chk("mis_halted", {31'b0, halted}, 32'h1);
    chk("mis_retired", retired, 32'd1);
    imem_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("mis_req", {31'b0, imem_req}, 32'h0);
    chk("mis_pc_frozen", pc, 32'h202);

    // reset colliding with a memory response
    do_reset();
    exec_one(NOPW, 0, 0, 0, 0, 0, 0);
    imem_ready = 0;
    tick(); tick();
    reset = 1; imem_ready = 1; imem_rdata = 32'h1234_5677;
    tick();
    chk("rst_ready_pc", pc, RP);
    chk("rst_ready_ret", retired, 32'd0);
    chk("rst_ready_valid", {31'b0, inst_valid}, 32'h0);
    reset = 0; imem_ready = 0;
    tick();
    chk("rst_ready_no_pulse", {31'b0, inst_valid}, 32'h0);
    chk("rst_ready_inst", inst, NOPW);

    // reset during EXEC: no commit
    imem_ready = 1; imem_rdata = NOPW;
    tick();
    imem_ready = 0; reset = 1; is_jal = 1; imm = 32'h40;
    tick();
    chk("rst_exec_ret", retired, 32'd0);
    chk("rst_exec_pc", pc, RP);
    reset = 0; clear_ctrl();

    // randomized run
    halt_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0) || (halt_cnt >= 4);
      imem_ready = ($urandom_range(0, 3) != 0);
      r = $urandom;
      imem_rdata = ($urandom_range(0, 4) == 0) ? {r[31:7], 7'h73} : r;
      case ($urandom_range(0, 2))
        0: x17_data = 32'd10;
        1: x17_data = 32'd9;
        default: x17_data = $urandom;
      endcase
      is_jalr = ($urandom_range(0, 7) == 0);
      is_jal  = ($urandom_range(0, 5) == 0);
      branch  = ($urandom_range(0, 3) == 0);
      bcond   = $urandom_range(0, 1) == 1;
      r = $urandom;
      imm = ($urandom_range(0, 24) == 0) ? r : {{20{r[11]}}, r[11:2], 2'b00};
      r = $urandom;
      rs1_data = ($urandom_range(0, 9) == 0) ? r : {r[31:2], 2'b00};
      tick();
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
